// File: rtl/vp_recovery_pkg.sv
// rtl/vp_recovery_pkg.sv - shared types and widths for the value-prediction recovery controller
package vp_recovery_pkg;

  // Core-wide widths normally supplied by the MIPS core header.
  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam int VP_REG_WIDTH = 5;

  typedef enum logic [2:0] {
    IDLE,
    SPEC,
    RESTORE,
    REDIRECT,
    INHIBIT
  } vp_rec_state_t;

  typedef struct packed {
    logic [VP_REG_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]   data;
  } undo_entry_t;

endpackage

// File: rtl/vp_undo_log.sv
// rtl/vp_undo_log.sv - undo LIFO holding pre-speculation register values
module vp_undo_log
  import vp_recovery_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  undo_entry_t push_entry,
  input  logic        pop,
  output undo_entry_t top_entry,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  undo_entry_t   mem [DEPTH];
  logic [CW-1:0] count;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign top_entry = mem[AW'(count - CW'(1))];

  // Pushes into a full log are silently dropped; the controller stalls writeback first.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (push && !full) begin
      mem[count[AW-1:0]] <= push_entry;
      count              <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/vp_recovery_ctrl.sv
// rtl/vp_recovery_ctrl.sv - load value-prediction recovery FSM (undo-log replay, squash, redirect)
// Optional VP_RECOVERY_DEBUG_EN: trace state changes, pushes and restores; flag log overflow.
module vp_recovery_ctrl
  import vp_recovery_pkg::*;
#(
  parameter int LOG_DEPTH = 8,
  parameter int REG_WIDTH = VP_REG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vp_out_valid,
  input  logic [ADDR_WIDTH-1:0] predicted_pc,
  input  logic                  recover,
  input  logic                  done,
  input  logic                  wb_valid,
  input  logic [REG_WIDTH-1:0]  wb_reg,
  input  logic [DATA_WIDTH-1:0] wb_old_data,
  input  logic                  dcache_valid,
  output logic                  recover_en,
  output logic                  stall_spec,
  output logic                  flush,
  output logic                  restore_valid,
  output logic [REG_WIDTH-1:0]  restore_reg,
  output logic [DATA_WIDTH-1:0] restore_data,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  recovery_done,
  output logic                  vp_inhibit
);

  vp_rec_state_t         state;
  logic [ADDR_WIDTH-1:0] cap_pc;
  logic                  log_push, log_pop, log_clear, log_full, log_empty;
  undo_entry_t           push_entry, log_top;

  // A write in the same cycle as the window closing belongs to neither outcome.
  assign log_push        = (state == SPEC) && wb_valid && (wb_reg != '0) && !recover && !done;
  assign log_pop         = (state == RESTORE) && !log_empty;
  assign log_clear       = (state == IDLE) || ((state == SPEC) && done && !recover);
  assign push_entry.rd   = VP_REG_WIDTH'(wb_reg);
  assign push_entry.data = wb_old_data;
  assign stall_spec      = log_full;

  vp_undo_log #(.DEPTH(LOG_DEPTH)) u_log (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (log_clear),
    .push       (log_push),
    .push_entry (push_entry),
    .pop        (log_pop),
    .top_entry  (log_top),
    .full       (log_full),
    .empty      (log_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cap_pc         <= '0;
      recover_en     <= 1'b0;
      flush          <= 1'b0;
      restore_valid  <= 1'b0;
      restore_reg    <= '0;
      restore_data   <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      recovery_done  <= 1'b0;
      vp_inhibit     <= 1'b0;
    end else begin
      flush          <= 1'b0;
      restore_valid  <= 1'b0;
      redirect_valid <= 1'b0;
      recovery_done  <= 1'b0;
      case (state)
        IDLE: if (vp_out_valid) begin
          state      <= SPEC;
          cap_pc     <= predicted_pc;
          recover_en <= 1'b1;
        end
        SPEC: if (recover) begin
          state      <= RESTORE;
          flush      <= 1'b1;
          recover_en <= 1'b0;
        end else if (done) begin
          state      <= IDLE;
          recover_en <= 1'b0;
        end
        RESTORE: if (!log_empty) begin
          restore_valid <= 1'b1;
          restore_reg   <= REG_WIDTH'(log_top.rd);
          restore_data  <= log_top.data;
        end else begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= cap_pc;
          recovery_done  <= 1'b1;
        end
        REDIRECT: begin
          state      <= INHIBIT;
          vp_inhibit <= 1'b1;
        end
        INHIBIT: if (dcache_valid) begin
          state      <= IDLE;
          vp_inhibit <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VP_RECOVERY_DEBUG_EN
  vp_rec_state_t state_q;
  logic          overflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state;
      if (state_q != state)
        $display("vp_recovery: state %s -> %s", state_q.name(), state.name());
      if (log_push && !log_full)
        $display("vp_recovery: push r%0d old=%h", wb_reg, wb_old_data);
      if (log_push && log_full) begin
        overflow_q <= 1'b1;
        $error("vp_recovery: undo log overflow, r%0d dropped", wb_reg);
      end
      if (log_pop)
        $display("vp_recovery: restore r%0d <= %h", log_top.rd, log_top.data);
    end
  end
`else
  // Release build: no monitors, identical ports and timing.
`endif

endmodule

// File: tb/tb_vp_recovery_ctrl.sv
// tb/tb_vp_recovery_ctrl.sv - randomized self-checking bench for vp_recovery_ctrl
module tb_vp_recovery_ctrl;
  import vp_recovery_pkg::*;

  localparam int LOG_DEPTH = 8;
  localparam int REG_WIDTH = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  vp_out_valid, recover, done, wb_valid, dcache_valid;
  logic [ADDR_WIDTH-1:0] predicted_pc;
  logic [REG_WIDTH-1:0]  wb_reg;
  logic [DATA_WIDTH-1:0] wb_old_data;
  logic                  recover_en, stall_spec, flush, restore_valid;
  logic [REG_WIDTH-1:0]  restore_reg;
  logic [DATA_WIDTH-1:0] restore_data;
  logic                  redirect_valid, recovery_done, vp_inhibit;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  // Reference model: the expected undo log as a plain queue plus the captured PC.
  logic [REG_WIDTH-1:0]  m_reg[$];
  logic [DATA_WIDTH-1:0] m_data[$];
  logic [ADDR_WIDTH-1:0] m_pc;

  always #5 clk = ~clk;

  vp_recovery_ctrl #(.LOG_DEPTH(LOG_DEPTH), .REG_WIDTH(REG_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .vp_out_valid(vp_out_valid), .predicted_pc(predicted_pc),
    .recover(recover), .done(done), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .wb_old_data(wb_old_data), .dcache_valid(dcache_valid), .recover_en(recover_en),
    .stall_spec(stall_spec), .flush(flush), .restore_valid(restore_valid),
    .restore_reg(restore_reg), .restore_data(restore_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .recovery_done(recovery_done), .vp_inhibit(vp_inhibit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    vp_out_valid = 0; recover = 0; done = 0; wb_valid = 0; dcache_valid = 0;
    predicted_pc = '0; wb_reg = '0; wb_old_data = '0;
  endtask

  task automatic open_window(input logic [ADDR_WIDTH-1:0] pc);
    vp_out_valid = 1; predicted_pc = pc;
    tick();
    vp_out_valid = 0; predicted_pc = $urandom;
    m_pc = pc; m_reg.delete(); m_data.delete();
    checks++;
    if (recover_en !== 1'b1) begin
      failures++; $display("FAIL open_window: recover_en=%b expected 1", recover_en);
    end
  endtask

  task automatic spec_wb(input bit v, input logic [REG_WIDTH-1:0] r, input logic [DATA_WIDTH-1:0] d);
    bit exp_stall;
    wb_valid = v; wb_reg = r; wb_old_data = d;
    vp_out_valid = 1'($urandom_range(0, 1)); predicted_pc = $urandom;
    exp_stall = (m_reg.size() == LOG_DEPTH);
    checks++;
    if (stall_spec !== exp_stall) begin
      failures++; $display("FAIL stall_spec: got %b expected %b (log=%0d)", stall_spec, exp_stall, m_reg.size());
    end
    tick();
    if (v && r != 0 && m_reg.size() < LOG_DEPTH) begin
      m_reg.push_back(r); m_data.push_back(d);
    end
    wb_valid = 0; vp_out_valid = 0;
    checks++;
    if (recover_en !== 1'b1) begin
      failures++; $display("FAIL spec_recover_en: got %b expected 1", recover_en);
    end
  endtask

  task automatic end_done();
    done = 1; wb_valid = 1; wb_reg = REG_WIDTH'($urandom_range(1, 31)); wb_old_data = $urandom;
    tick();
    quiet();
    checks++;
    if ({recover_en, flush} !== 2'b00) begin
      failures++; $display("FAIL done_close: recover_en=%b flush=%b expected 0 0", recover_en, flush);
    end
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1'($urandom_range(0, 1)); wb_reg = REG_WIDTH'($urandom_range(1, 31));
      tick();
      checks++;
      if ({restore_valid, redirect_valid, recovery_done, vp_inhibit, stall_spec} !== 5'b0) begin
        failures++;
        $display("FAIL done_quiet: rv=%b redir=%b rdone=%b inh=%b stall=%b expected all 0",
                 restore_valid, redirect_valid, recovery_done, vp_inhibit, stall_spec);
      end
    end
    quiet();
    m_reg.delete(); m_data.delete();
  endtask

  task automatic end_recover(input bit also_done, input logic [REG_WIDTH-1:0] same_reg, input int dwait);
    int n;
    n = m_reg.size();
    recover = 1; done = also_done; wb_valid = 1; wb_reg = same_reg; wb_old_data = $urandom;
    tick();
    quiet();
    checks++;
    if ({flush, restore_valid, recover_en, recovery_done} !== 4'b1000) begin
      failures++;
      $display("FAIL flush_cycle: flush=%b rv=%b ren=%b rdone=%b expected 1 0 0 0",
               flush, restore_valid, recover_en, recovery_done);
    end
    for (int i = n - 1; i >= 0; i--) begin
      wb_valid = 1'($urandom_range(0, 1)); wb_reg = REG_WIDTH'($urandom_range(1, 31));
      tick();
      checks++;
      if ({restore_valid, flush, recovery_done} !== 3'b100 || restore_reg !== m_reg[i] ||
          restore_data !== m_data[i]) begin
        failures++;
        $display("FAIL restore_%0d: got v=%b r=%0d d=%h expected v=1 r=%0d d=%h",
                 i, restore_valid, restore_reg, restore_data, m_reg[i], m_data[i]);
      end
    end
    wb_valid = 0;
    tick();
    checks++;
    if ({restore_valid, redirect_valid, recovery_done} !== 3'b011 || redirect_pc !== m_pc) begin
      failures++;
      $display("FAIL redirect: rv=%b redir=%b rdone=%b pc=%h expected 0 1 1 pc=%h",
               restore_valid, redirect_valid, recovery_done, redirect_pc, m_pc);
    end
    tick();
    checks++;
    if ({redirect_valid, recovery_done, vp_inhibit} !== 3'b001) begin
      failures++;
      $display("FAIL inhibit_entry: redir=%b rdone=%b inh=%b expected 0 0 1",
               redirect_valid, recovery_done, vp_inhibit);
    end
    for (int k = 0; k < dwait; k++) begin
      tick();
      checks++;
      if ({vp_inhibit, recover_en} !== 2'b10) begin
        failures++; $display("FAIL inhibit_hold: inh=%b ren=%b expected 1 0", vp_inhibit, recover_en);
      end
    end
    dcache_valid = 1;
    tick();
    dcache_valid = 0;
    checks++;
    if (vp_inhibit !== 1'b0) begin
      failures++; $display("FAIL inhibit_release: inh=%b expected 0", vp_inhibit);
    end
    m_reg.delete(); m_data.delete();
  endtask

  task automatic test_reset();
    rst_n = 0; quiet();
    tick(); tick();
    checks++;
    if ({recover_en, stall_spec, flush, restore_valid, restore_reg, restore_data, redirect_valid,
         redirect_pc, recovery_done, vp_inhibit} !== '0) begin
      failures++; $display("FAIL reset_outputs: some output nonzero (ren=%b rv=%b inh=%b pc=%h)",
                           recover_en, restore_valid, vp_inhibit, redirect_pc);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_correct_prediction();
    open_window(32'h40);
    spec_wb(1, 5'd3, 32'h11);
    end_done();
  endtask

  task automatic test_mispredict();
    open_window(32'h40);
    spec_wb(1, 5'd3, 32'h11);
    spec_wb(1, 5'd5, 32'h22);
    spec_wb(1, 5'd7, 32'h33);
    end_recover(0, 5'd9, 1);
  endtask

  task automatic test_empty_recover();
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1; wb_reg = REG_WIDTH'($urandom_range(1, 31)); wb_old_data = $urandom;
      tick();
    end
    quiet();
    open_window(32'h1000);
    end_recover(0, 5'd4, 0);
  endtask

  task automatic test_full_log();
    open_window(32'h2000);
    for (int k = 0; k < LOG_DEPTH + 1; k++)
      spec_wb(1, REG_WIDTH'($urandom_range(1, 31)), $urandom);
    checks++;
    if (m_reg.size() != LOG_DEPTH || stall_spec !== 1'b1) begin
      failures++; $display("FAIL full_log: stall=%b model=%0d expected 1 and %0d", stall_spec, m_reg.size(), LOG_DEPTH);
    end
    end_recover(0, 5'd2, 2);
  endtask

  task automatic test_recover_and_done();
    open_window(32'h3000);
    spec_wb(1, 5'd0, 32'hdead);
    spec_wb(1, 5'd12, 32'h1234);
    end_recover(1, 5'd0, 1);
  endtask

  task automatic test_reset_mid_restore();
    open_window(32'h4000);
    spec_wb(1, 5'd1, 32'haa);
    spec_wb(1, 5'd2, 32'hbb);
    spec_wb(1, 5'd3, 32'hcc);
    recover = 1; tick(); quiet();
    tick();
    checks++;
    if (restore_valid !== 1'b1 || restore_reg !== 5'd3) begin
      failures++; $display("FAIL mid_first_restore: v=%b r=%0d expected 1 3", restore_valid, restore_reg);
    end
    tick();
    rst_n = 0;
    tick();
    checks++;
    if ({recover_en, stall_spec, flush, restore_valid, restore_reg, restore_data, redirect_valid,
         redirect_pc, recovery_done, vp_inhibit} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: rv=%b r=%0d ren=%b expected all 0",
                           restore_valid, restore_reg, recover_en);
    end
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      wb_valid = 1; wb_reg = REG_WIDTH'($urandom_range(1, 31));
      tick();
      checks++;
      if ({restore_valid, recover_en, recovery_done} !== 3'b000) begin
        failures++; $display("FAIL post_reset_idle: rv=%b ren=%b rdone=%b expected 0 0 0",
                             restore_valid, recover_en, recovery_done);
      end
    end
    quiet();
    m_reg.delete(); m_data.delete();
    open_window(32'h4400);
    end_recover(0, 5'd6, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int nwb;
      open_window($urandom);
      nwb = $urandom_range(0, 12);
      for (int k = 0; k < nwb; k++)
        spec_wb(1'($urandom_range(0, 1)), REG_WIDTH'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 2) == 0)
        end_done();
      else
        end_recover(1'($urandom_range(0, 1)), REG_WIDTH'($urandom_range(0, 31)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_correct_prediction();
    test_mispredict();
    test_empty_recover();
    test_full_log();
    test_recover_and_done();
    test_reset_mid_restore();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
